// File: rtl/magic_pkg.sv
// rtl/magic_pkg.sv - shared opcodes, states and default sizes for the MAGIC NOR executor
package magic_pkg;

  localparam int NUM_CELLS_DEF = 32;
  localparam int ADDR_W_DEF    = 5;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    OP_NOR2 = 2'b00,
    OP_INV1 = 2'b01,
    OP_READ = 2'b10,
    OP_END  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_INIT  = 2'b01,
    ST_EVAL  = 2'b10,
    ST_OUT   = 2'b11
  } state_e;

endpackage

// File: rtl/magic_row_cells.sv
// rtl/magic_row_cells.sv - one emulated crossbar row: single-bit cells, two read ports, one write port
module magic_row_cells
  import magic_pkg::*;
#(
  parameter int NUM_CELLS = NUM_CELLS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              wbit_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic              rbit_a_o,
  output logic              rbit_b_o
);

  // Widened by one bit so the range test stays meaningful when NUM_CELLS == 2**ADDR_W
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(NUM_CELLS);

  logic [NUM_CELLS-1:0] cells_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_q <= '0;
    end else if (we_i && ({1'b0, waddr_i} < LIM)) begin
      cells_q[waddr_i] <= wbit_i;
    end
  end

  assign rbit_a_o = ({1'b0, raddr_a_i} < LIM) ? cells_q[raddr_a_i] : 1'b0;
  assign rbit_b_o = ({1'b0, raddr_b_i} < LIM) ? cells_q[raddr_b_i] : 1'b0;

endmodule

// File: rtl/magic_nor_exec.sv
// rtl/magic_nor_exec.sv - sequential NOR/INV netlist executor emulating one MAGIC crossbar row
module magic_nor_exec
  import magic_pkg::*;
#(
  parameter int NUM_CELLS = NUM_CELLS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_bit,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_a,
  input  logic [ADDR_W-1:0] instr_b,
  input  logic [ADDR_W-1:0] instr_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  gate_cnt
);

  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(NUM_CELLS);

  state_e            state_q, state_d;
  op_e               op_q, op_in;
  logic [ADDR_W-1:0] a_q, b_q, dst_q, rd_addr_a, waddr;
  logic              alive_q, done_q, err_q, out_bit_q;
  logic [CNT_W-1:0]  gate_cnt_q;
  logic              accept, illegal, ok_a, ok_b, ok_d;
  logic              we, wbit, rd_a, rd_b;

  assign op_in  = op_e'(instr_op);
  assign accept = instr_valid && instr_ready;
  assign ok_a   = {1'b0, instr_a} < LIM;
  assign ok_b   = {1'b0, instr_b} < LIM;
  assign ok_d   = {1'b0, instr_dst} < LIM;

  // MAGIC cannot evaluate in place: the output cell must differ from every input cell
  always_comb begin
    illegal = 1'b0;
    case (op_in)
      OP_NOR2: illegal = !ok_a || !ok_b || !ok_d || (instr_dst == instr_a) || (instr_dst == instr_b);
      OP_INV1: illegal = !ok_a || !ok_d || (instr_dst == instr_a);
      OP_READ: illegal = !ok_a;
      default: illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (accept && !illegal) begin
          if (op_in == OP_NOR2 || op_in == OP_INV1) state_d = ST_INIT;
          else if (op_in == OP_READ)                state_d = ST_OUT;
        end
      end
      ST_INIT: state_d = ST_EVAL;
      ST_EVAL: state_d = ST_FETCH;
      ST_OUT:  if (out_ready) state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Row write port: host loads in FETCH, LRS initialise in INIT, conditional reset in EVAL
  always_comb begin
    instr_ready = alive_q && (state_q == ST_FETCH) && !load_valid;
    out_valid   = (state_q == ST_OUT);
    rd_addr_a   = (state_q == ST_FETCH) ? instr_a : a_q;
    we          = 1'b0;
    waddr       = dst_q;
    wbit        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        we    = load_valid;
        waddr = load_addr;
        wbit  = load_bit;
      end
      ST_INIT: begin
        we   = 1'b1;
        wbit = 1'b1;
      end
      ST_EVAL: begin
        we   = 1'b1;
        wbit = ~(rd_a | (rd_b & (op_q == OP_NOR2)));
      end
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NOR2;
      a_q        <= '0;
      b_q        <= '0;
      dst_q      <= '0;
      alive_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      out_bit_q  <= 1'b0;
      gate_cnt_q <= '0;
    end else begin
      alive_q <= 1'b1;
      done_q  <= accept && (op_in == OP_END);
      if (accept) begin
        op_q  <= op_in;
        a_q   <= instr_a;
        b_q   <= instr_b;
        dst_q <= instr_dst;
      end
      if (accept && (op_in == OP_READ) && !illegal) out_bit_q <= rd_a;
      if (accept && (op_in == OP_END)) begin
        err_q      <= 1'b0;
        gate_cnt_q <= '0;
      end else begin
        if (accept && illegal) err_q <= 1'b1;
        if ((state_q == ST_EVAL) && (gate_cnt_q != '1)) gate_cnt_q <= gate_cnt_q + CNT_W'(1);
      end
    end
  end

  magic_row_cells #(
    .NUM_CELLS(NUM_CELLS),
    .ADDR_W   (ADDR_W)
  ) u_cells (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (we),
    .waddr_i  (waddr),
    .wbit_i   (wbit),
    .raddr_a_i(rd_addr_a),
    .raddr_b_i(b_q),
    .rbit_a_o (rd_a),
    .rbit_b_o (rd_b)
  );

  assign out_bit  = out_bit_q;
  assign done     = done_q;
  assign err      = err_q;
  assign gate_cnt = gate_cnt_q;

endmodule

// File: tb/tb_magic_nor_exec.sv
// tb/tb_magic_nor_exec.sv - scoreboard bench for magic_nor_exec against a cell-array reference model
module tb_magic_nor_exec;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [4:0]  load_addr = '0;
  logic        load_bit = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [1:0]  instr_op = '0;
  logic [4:0]  instr_a = '0;
  logic [4:0]  instr_b = '0;
  logic [4:0]  instr_dst = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_bit;
  logic        done;
  logic        err;
  logic [15:0] gate_cnt;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   xfers = 0;
  bit   mdl [N];
  bit   exp_err = 1'b0;
  int   exp_cnt = 0;
  bit   sb [$];

  magic_nor_exec dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_addr(load_addr), .load_bit(load_bit),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_a(instr_a), .instr_b(instr_b), .instr_dst(instr_dst),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .done(done), .err(err), .gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_fetch();
    int n = 0;
    #1;
    while (!instr_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_wait", 32'(instr_ready), 1);
  endtask

  task automatic do_load(input int addr, input bit b);
    @(negedge clk);
    wait_fetch();
    load_valid = 1'b1;
    load_addr  = 5'(addr);
    load_bit   = b;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    if (addr < N) mdl[addr] = b;
  endtask

  task automatic issue(input int op, input int a, input int b, input int d, output int acc);
    bit bad;
    @(negedge clk);
    instr_op    = 2'(op);
    instr_a     = 5'(a);
    instr_b     = 5'(b);
    instr_dst   = 5'(d);
    instr_valid = 1'b1;
    wait_fetch();
    @(posedge clk);
    #1;
    acc = cyc;
    instr_valid = 1'b0;
    case (op)
      0: bad = (a >= N) || (b >= N) || (d >= N) || (d == a) || (d == b);
      1: bad = (a >= N) || (d >= N) || (d == a);
      2: bad = (a >= N);
      default: bad = 1'b0;
    endcase
    if (op == 3) begin
      exp_err = 1'b0;
      exp_cnt = 0;
    end else if (bad) begin
      exp_err = 1'b1;
    end else if (op == 2) begin
      sb.push_back(mdl[a]);
    end else begin
      mdl[d] = (op == 0) ? !(mdl[a] || mdl[b]) : !mdl[a];
      if (exp_cnt < 65535) exp_cnt++;
    end
  endtask

  initial begin
    int acc1, acc2, t, xf, n;
    bit ob, v0, v1;
    int g_op [15];
    int g_a [15];
    int g_b [15];

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (out_valid && out_ready) begin
            xfers++;
            if (sb.size() == 0) chk("unexpected_out", 32'(out_valid), 0);
            else chk("read_bit", 32'(out_bit), 32'(sb.pop_front()));
          end
          if (done) chk("done_vs_out_valid", 32'(out_valid), 0);
        end
      end
    join_none

    for (int i = 0; i < N; i++) mdl[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_instr_ready", 32'(instr_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_bit", 32'(out_bit), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_gate_cnt", 32'(gate_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_ready", 32'(instr_ready), 1);
    issue(2, 7, 0, 0, t);

    do_load(0, 1'b1);
    do_load(1, 1'b0);
    issue(0, 0, 1, 2, acc1);
    issue(1, 2, 13, 3, acc2);
    chk("gate_spacing", 32'(acc2 - acc1), 3);
    issue(2, 2, 0, 0, t);
    issue(2, 3, 0, 0, t);
    chk("gate_cnt_basic", 32'(gate_cnt), 2);
    chk("gate_cnt_model", 32'(gate_cnt), 32'(exp_cnt));

    for (int v = 0; v < 4; v++) begin
      do_load(0, v[1]);
      do_load(1, v[0]);
      issue(0, 0, 1, 2, t);
      issue(2, 2, 0, 0, t);
    end

    for (int g = 0; g < 15; g++) begin
      g_op[g] = int'($urandom_range(0, 1));
      g_a[g]  = int'($urandom_range(0, 3 + g));
      g_b[g]  = int'($urandom_range(0, 3 + g));
    end
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) do_load(i, 1'($urandom));
      for (int g = 0; g < 15; g++) issue(g_op[g], g_a[g], g_b[g], 4 + g, t);
      for (int g = 0; g < 15; g++) issue(2, 4 + g, 0, 0, t);
    end

    @(negedge clk);
    wait_fetch();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(2, 18, 0, 0, t);
    ob = out_bit;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_bit", 32'(out_bit), 32'(ob));
      chk("bp_instr_ready", 32'(instr_ready), 0);
    end
    @(posedge clk);
    #1;
    xf = xfers;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp_one_xfer", 32'(xfers - xf), 1);
    chk("bp_out_valid_low", 32'(out_valid), 0);

    do_load(5, 1'b1);
    do_load(6, 1'b0);
    n = exp_cnt;
    issue(0, 5, 6, 5, t);
    chk("illegal_err", 32'(err), 1);
    chk("illegal_err_model", 32'(err), 32'(exp_err));
    @(negedge clk);
    chk("illegal_gate_cnt", 32'(gate_cnt), 32'(n));
    issue(2, 5, 0, 0, t);
    issue(1, 6, 0, 7, t);
    issue(0, 6, 7, 40, t);
    chk("err_sticky", 32'(err), 1);

    @(negedge clk);
    wait_fetch();
    v1 = !mdl[9];
    load_valid = 1'b1;
    load_addr = 5'd9;
    load_bit = v1;
    instr_valid = 1'b1;
    instr_op = 2'd2;
    instr_a = 5'd9;
    #1;
    chk("prio_ready_low", 32'(instr_ready), 0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    mdl[9] = v1;
    #1;
    chk("prio_ready_next", 32'(instr_ready), 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    sb.push_back(mdl[9]);

    issue(3, 0, 0, 0, t);
    chk("end_done", 32'(done), 1);
    chk("end_err", 32'(err), 0);
    chk("end_gate_cnt", 32'(gate_cnt), 0);
    @(posedge clk);
    #1;
    chk("end_done_pulse", 32'(done), 0);

    do_load(0, 1'b0);
    do_load(1, 1'b0);
    issue(1, 0, 0, 21, t);
    issue(0, 0, 1, 20, t);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr_ready", 32'(instr_ready), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_gate_cnt", 32'(gate_cnt), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_done", 32'(done), 0);
    for (int i = 0; i < N; i++) mdl[i] = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(2, 0, 0, 0, t);
    issue(2, 20, 0, 0, t);
    issue(2, 21, 0, 0, t);
    issue(2, 9, 0, 0, t);

    v0 = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'(v0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
